// File: rtl/audio_capture_ctrl.sv
// Avalon-MM capture controller: selects/mixes codec samples, optionally waits for a
// level trigger, streams a bounded run into the sample BRAM and exposes status/readback.
module audio_capture_ctrl #(
  parameter int SAMPLE_W = 24,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 48000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] adc_left,
  input  logic [SAMPLE_W-1:0] adc_right,
  output logic                bram_we,
  output logic [ADDR_W-1:0]   bram_wa,
  output logic [SAMPLE_W-1:0] bram_din,
  output logic [ADDR_W-1:0]   bram_ra,
  input  logic [SAMPLE_W-1:0] bram_dout,
  output logic                irq
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;
  state_t r_state, w_next;

  logic [CNT_W-1:0]    r_limit, r_lim_run, r_count;
  logic [SAMPLE_W-1:0] r_thresh, r_live, r_din;
  logic [ADDR_W-1:0]   r_wa, r_ra;
  logic [1:0]          r_chsel;
  logic                r_irq_en, r_done, r_we;
  logic [31:0]         r_rdata;

  logic [SAMPLE_W-1:0] w_sel, w_mono, w_abs;
  logic                w_wr, w_start, w_abort, w_busy, w_start_ok, w_trig, w_cap, w_rd_status;

  assign w_wr        = chipselect && write;
  assign w_abort     = w_wr && (address == 3'd0) && writedata[1];
  assign w_start     = w_wr && (address == 3'd0) && writedata[0] && !writedata[1];
  assign w_busy      = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign w_start_ok  = w_start && !w_busy;
  assign w_rd_status = chipselect && read && (address == 3'd4);

  // Halving both channels before the add keeps the mix inside SAMPLE_W bits.
  assign w_mono = ($signed(adc_left) >>> 1) + ($signed(adc_right) >>> 1);

  always_comb begin
    w_sel = w_mono;
    case (r_chsel)
      2'd1:    w_sel = adc_left;
      2'd2:    w_sel = adc_right;
      default: w_sel = w_mono;
    endcase
  end

  always_comb begin
    w_abs = w_sel;
    if (w_sel[SAMPLE_W-1]) begin
      if (w_sel == {1'b1, {(SAMPLE_W-1){1'b0}}}) w_abs = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else                                       w_abs = -w_sel;
    end
  end

  assign w_trig = w_abs >= r_thresh;
  assign w_cap  = sample_valid && !w_abort &&
                  ((r_state == S_CAPTURE) || ((r_state == S_ARMED) && w_trig));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) w_next = S_IDLE;
        if (w_start_ok) begin
          if (r_limit == '0)      w_next = S_DONE;
          else if (writedata[4])  w_next = S_ARMED;
          else                    w_next = S_CAPTURE;
        end
      end
      S_ARMED: begin
        if (w_abort)                     w_next = S_IDLE;
        else if (sample_valid && w_trig) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_abort)                                              w_next = S_IDLE;
        else if (r_we && ((r_count + CNT_W'(1)) >= r_lim_run))    w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_limit   <= CNT_W'(DEPTH);
      r_lim_run <= '0;
      r_count   <= '0;
      r_thresh  <= '0;
      r_live    <= '0;
      r_din     <= '0;
      r_wa      <= '0;
      r_ra      <= '0;
      r_chsel   <= '0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          3'd0: r_irq_en <= writedata[5];
          3'd1: r_limit  <= (writedata > 32'(DEPTH)) ? CNT_W'(DEPTH) : CNT_W'(writedata);
          3'd2: r_thresh <= writedata[SAMPLE_W-1:0];
          3'd3: r_ra     <= writedata[ADDR_W-1:0];
          default: ;
        endcase
      end
      if (w_start_ok) begin
        r_lim_run <= r_limit;
        r_chsel   <= writedata[3:2];
      end
      if (sample_valid) r_live <= w_sel;

      // Write address is the pre-increment count; the count bumps as the pulse retires.
      r_we <= w_cap;
      if (w_cap) begin
        r_wa  <= ADDR_W'(r_count);
        r_din <= w_sel;
      end
      if (w_start_ok) r_count <= '0;
      else if (r_we)  r_count <= r_count + CNT_W'(1);

      if (w_next == S_DONE)              r_done <= 1'b1;
      else if (w_start_ok || w_rd_status) r_done <= 1'b0;

      r_rdata <= '0;
      if (chipselect && read) begin
        case (address)
          3'd4:    r_rdata <= {29'b0, r_done, (r_state == S_ARMED), w_busy};
          3'd5:    r_rdata <= 32'(r_count);
          3'd6:    r_rdata <= 32'($signed(bram_dout));
          3'd7:    r_rdata <= 32'($signed(r_live));
          default: r_rdata <= '0;
        endcase
      end
    end
  end

  assign readdata = r_rdata;
  assign bram_we  = r_we;
  assign bram_wa  = r_wa;
  assign bram_din = r_din;
  assign bram_ra  = r_ra;
  assign irq      = r_done && r_irq_en;
endmodule

// File: tb/tb_audio_capture_ctrl.sv
// Directed bench for audio_capture_ctrl with a small BRAM model and a write log.
// DEPTH is shrunk to 40 so the clamp case runs in a few hundred cycles.
module tb_audio_capture_ctrl;
  localparam int SW = 24;
  localparam int AW = 6;
  localparam int DP = 40;

  logic          clk = 1'b0;
  logic          reset, chipselect, write, read, sample_valid;
  logic [2:0]    address;
  logic [31:0]   writedata, readdata;
  logic [SW-1:0] adc_left, adc_right, bram_din, bram_dout;
  logic [AW-1:0] bram_wa, bram_ra;
  logic          bram_we, irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audio_capture_ctrl #(.SAMPLE_W(SW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .sample_valid(sample_valid), .adc_left(adc_left), .adc_right(adc_right),
    .bram_we(bram_we), .bram_wa(bram_wa), .bram_din(bram_din), .bram_ra(bram_ra),
    .bram_dout(bram_dout), .irq(irq)
  );

  logic [SW-1:0] mem [2**AW];
  logic [AW-1:0] log_wa[$];
  logic [SW-1:0] log_din[$];
  int            we_cnt = 0;
  int            dbl    = 0;
  logic          prev_we = 1'b0;

  always @(posedge clk) begin
    if (bram_we) begin
      mem[bram_wa] <= bram_din;
      log_wa.push_back(bram_wa);
      log_din.push_back(bram_din);
      we_cnt++;
    end
    if (bram_we && prev_we) dbl++;
    prev_we   <= bram_we;
    bram_dout <= mem[bram_ra];
  end

  task automatic avl_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); chipselect = 1; write = 1; address = a; writedata = d;
    @(negedge clk); chipselect = 0; write = 0;
  endtask

  task automatic avl_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); chipselect = 1; read = 1; address = a;
    @(negedge clk); d = readdata; chipselect = 0; read = 0;
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
    @(negedge clk); sample_valid = 1; adc_left = l; adc_right = r;
    @(negedge clk); sample_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1; chipselect = 0; write = 0; read = 0; address = 0; writedata = 0;
    sample_valid = 0; adc_left = 0; adc_right = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL reset_we got %b exp 0", bram_we); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got %b exp 0", irq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h exp 0", readdata); end
    avl_rd(3'd4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got %h exp 0", d); end
    avl_rd(3'd5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_count got %h exp 0", d); end
    avl_rd(3'd7, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_live got %h exp 0", d); end
    total++; if (we_cnt !== 0) begin bad++; $display("FAIL reset_nowrite got %0d exp 0", we_cnt); end
  endtask

  task automatic test_chsel_left;
    logic [31:0] d;
    int b = log_wa.size();
    avl_wr(3'd1, 32'd4);
    avl_wr(3'd0, 32'h25);  // START, CHSEL=left, IRQ_EN
    avl_rd(3'd4, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL left_busy got %h exp 1", d); end
    for (int i = 1; i <= 6; i++) send(SW'(i), '0);
    total++; if (log_wa.size() - b !== 4) begin bad++; $display("FAIL left_nwr got %0d exp 4", log_wa.size() - b); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (log_wa[b+i] !== AW'(i)) begin bad++; $display("FAIL left_wa%0d got %0d exp %0d", i, log_wa[b+i], i); end
      total++; if (log_din[b+i] !== SW'(i+1)) begin bad++; $display("FAIL left_din%0d got %0d exp %0d", i, log_din[b+i], i+1); end
    end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL left_irq got %b exp 1", irq); end
    avl_rd(3'd4, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL left_status got %h exp 4", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL left_irq_clr got %b exp 0", irq); end
    avl_rd(3'd4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL left_status_clr got %h exp 0", d); end
    avl_rd(3'd5, d);
    total++; if (d !== 32'd4) begin bad++; $display("FAIL left_count got %0d exp 4", d); end
    avl_rd(3'd7, d);
    total++; if (d !== 32'd6) begin bad++; $display("FAIL left_live got %0d exp 6", d); end
  endtask

  task automatic test_mono;
    logic [31:0] d;
    int b = log_wa.size();
    avl_wr(3'd1, 32'd1);
    avl_wr(3'd0, 32'h01);
    send(SW'(-8), SW'(4));
    total++; if (log_wa.size() - b !== 1) begin bad++; $display("FAIL mono_nwr got %0d exp 1", log_wa.size() - b); end
    else begin
      total++; if (log_din[b] !== 24'hFFFFFE) begin bad++; $display("FAIL mono_din got %h exp fffffe", log_din[b]); end
      total++; if (log_wa[b] !== AW'(0)) begin bad++; $display("FAIL mono_wa got %0d exp 0", log_wa[b]); end
    end
    avl_wr(3'd3, 32'd3);
    avl_wr(3'd3, 32'd0);
    @(negedge clk);
    avl_rd(3'd6, d);
    total++; if (d !== 32'hFFFFFFFE) begin bad++; $display("FAIL mono_data got %h exp fffffffe", d); end
    avl_rd(3'd7, d);
    total++; if (d !== 32'hFFFFFFFE) begin bad++; $display("FAIL mono_live got %h exp fffffffe", d); end
  endtask

  task automatic test_trigger;
    logic [31:0] d;
    int b = log_wa.size();
    avl_wr(3'd1, 32'd2);
    avl_wr(3'd2, 32'd100);
    avl_wr(3'd0, 32'h15);  // START, CHSEL=left, TRIG_EN
    avl_rd(3'd4, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL trig_armed got %h exp 3", d); end
    send(SW'(5), '0);
    send(SW'(-50), '0);
    total++; if (log_wa.size() - b !== 0) begin bad++; $display("FAIL trig_early got %0d exp 0", log_wa.size() - b); end
    send(SW'(-120), '0);
    send(SW'(30), '0);
    total++; if (log_wa.size() - b !== 2) begin bad++; $display("FAIL trig_nwr got %0d exp 2", log_wa.size() - b); end
    else begin
      total++; if (log_din[b] !== 24'hFFFF88 || log_wa[b] !== AW'(0)) begin bad++; $display("FAIL trig_w0 got %h@%0d exp ffff88@0", log_din[b], log_wa[b]); end
      total++; if (log_din[b+1] !== 24'd30 || log_wa[b+1] !== AW'(1)) begin bad++; $display("FAIL trig_w1 got %h@%0d exp 1e@1", log_din[b+1], log_wa[b+1]); end
    end
    avl_rd(3'd5, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL trig_count got %0d exp 2", d); end
    avl_rd(3'd4, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL trig_status got %h exp 4", d); end
  endtask

  task automatic test_abort;
    logic [31:0] d;
    int b = log_wa.size();
    avl_wr(3'd1, 32'd10);
    avl_wr(3'd0, 32'h05);
    send(SW'(1), '0);
    send(SW'(2), '0);
    avl_wr(3'd0, 32'h01);  // START while busy, would switch to mono if honoured
    send(SW'(3), '0);
    avl_rd(3'd5, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL busy_start_count got %0d exp 3", d); end
    total++; if (log_din[log_din.size()-1] !== 24'd3) begin bad++; $display("FAIL busy_start_din got %0d exp 3", log_din[log_din.size()-1]); end
    avl_wr(3'd0, 32'h02);
    @(negedge clk);
    avl_rd(3'd4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_status got %h exp 0", d); end
    avl_rd(3'd5, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL abort_count got %0d exp 3", d); end
    send(SW'(4), '0);
    send(SW'(5), '0);
    total++; if (log_wa.size() - b !== 3) begin bad++; $display("FAIL abort_nwr got %0d exp 3", log_wa.size() - b); end
    avl_wr(3'd0, 32'h07);  // START+ABORT together
    avl_rd(3'd4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL startabort_status got %h exp 0", d); end
    avl_rd(3'd5, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL startabort_count got %0d exp 3", d); end
    avl_wr(3'd0, 32'h05);
    avl_rd(3'd5, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL restart_count got %0d exp 0", d); end
    avl_rd(3'd4, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL restart_status got %h exp 1", d); end
    avl_wr(3'd0, 32'h02);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_limits;
    logic [31:0] d;
    int b = log_wa.size();
    avl_wr(3'd1, 32'd60000);
    avl_wr(3'd0, 32'h05);
    for (int i = 1; i <= DP + 5; i++) send(SW'(i), '0);
    total++; if (log_wa.size() - b !== DP) begin bad++; $display("FAIL clamp_nwr got %0d exp %0d", log_wa.size() - b, DP); end
    else begin
      total++; if (log_din[b+DP-1] !== SW'(DP) || log_wa[b+DP-1] !== AW'(DP-1)) begin bad++; $display("FAIL clamp_last got %0d@%0d exp %0d@%0d", log_din[b+DP-1], log_wa[b+DP-1], DP, DP-1); end
    end
    avl_rd(3'd5, d);
    total++; if (d !== 32'(DP)) begin bad++; $display("FAIL clamp_count got %0d exp %0d", d, DP); end
    avl_rd(3'd4, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL clamp_status got %h exp 4", d); end
    b = log_wa.size();
    avl_wr(3'd1, 32'd0);
    avl_wr(3'd0, 32'h05);
    send(SW'(7), '0);
    avl_rd(3'd4, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL zero_status got %h exp 4", d); end
    avl_rd(3'd5, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL zero_count got %0d exp 0", d); end
    total++; if (log_wa.size() - b !== 0) begin bad++; $display("FAIL zero_nwr got %0d exp 0", log_wa.size() - b); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    avl_wr(3'd1, 32'd10);
    avl_wr(3'd0, 32'h05);
    send(SW'(1), '0);
    @(negedge clk); sample_valid = 1; adc_left = SW'(2);
    @(negedge clk); sample_valid = 0; reset = 1;
    @(negedge clk); reset = 0;
    total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL midrst_we got %b exp 0", bram_we); end
    avl_rd(3'd4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL midrst_status got %h exp 0", d); end
    avl_rd(3'd5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL midrst_count got %0d exp 0", d); end
    total++; if (dbl !== 0) begin bad++; $display("FAIL we_width got %0d long pulses exp 0", dbl); end
  endtask

  initial begin
    test_reset;
    test_chsel_left;
    test_mono;
    test_trigger;
    test_abort;
    test_limits;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
